// File: rtl/fifo_wr_arbiter_ctrl.sv
// Write-side arbiter and pointer/occupancy controller for an external FIFO memory.
// Two producers share the write port round-robin; the consumer sees the memory read port directly.
module fifo_wr_arbiter_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  W_CLK,
   input  logic                  W_RST,
   input  logic                  flush,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_ready,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  last_grant
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  last_grant_q, last_grant_d;
   logic                  blocked, gnt0, gnt1, push, pop;

   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);

   // Reset also blocks grants so producers never see a handshake that gets discarded.
   always_comb begin
      blocked = W_RST | flush | full;
      gnt0    = ~blocked & req0_valid & (~req1_valid | last_grant_q);
      gnt1    = ~blocked & req1_valid & (~req0_valid | ~last_grant_q);
      push    = gnt0 | gnt1;
      pop     = ~W_RST & ~flush & ~empty & rd_ready;
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign mem_wr_en   = push;
   assign mem_wr_addr = wr_ptr_q;
   assign mem_wr_data = gnt1 ? req1_data : req0_data;
   assign mem_rd_addr = rd_ptr_q;
   assign rd_valid    = ~empty;
   assign rd_data     = mem_rd_data;
   assign fill_level  = count_q;
   assign last_grant  = last_grant_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      last_grant_d = last_grant_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            last_grant_d = gnt1;
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge W_CLK) begin
      if (W_RST) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Bench for fifo_wr_arbiter_ctrl: directed vector table, hand corner sequences, then random traffic
// against a queue-based model of the FIFO with an 8-entry memory modelled alongside.
module tb_fifo_wr_arbiter_ctrl;

   logic       W_CLK, W_RST, flush;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic       mem_wr_en;
   logic [2:0] mem_wr_addr, mem_rd_addr;
   logic [7:0] mem_wr_data, mem_rd_data, rd_data;
   logic       rd_valid, rd_ready, full, empty, last_grant;
   logic [3:0] fill_level;

   fifo_wr_arbiter_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .ADDR_WIDTH(3)) dut (
      .W_CLK(W_CLK), .W_RST(W_RST), .flush(flush),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .full(full), .empty(empty), .fill_level(fill_level), .last_grant(last_grant)
   );

   // FIFO storage: synchronous write, combinational read
   logic [7:0] mem [8];
   always @(posedge W_CLK) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   assign mem_rd_data = mem[mem_rd_addr];

   initial W_CLK = 1'b0;
   always #5 W_CLK = ~W_CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic rr);
      W_RST = rst; flush = fl; req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1; rd_ready = rr;
   endtask

   task automatic tick();
      @(posedge W_CLK);
      #1;
   endtask

   typedef struct {
      logic       rst, fl, v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       rr, r0, r1;
      logic [2:0] wa;
      logic       rv;
      logic [7:0] rd;
      logic [3:0] fill;
      logic       lg;
   } vec_t;

   function automatic vec_t mk(logic rst, logic fl, logic v0, logic [7:0] d0, logic v1,
                               logic [7:0] d1, logic rr, logic r0, logic r1, logic [2:0] wa,
                               logic rv, logic [7:0] rd, logic [3:0] fill, logic lg);
      vec_t v;
      v.rst = rst; v.fl = fl; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rr = rr;
      v.r0 = r0; v.r1 = r1; v.wa = wa; v.rv = rv; v.rd = rd; v.fill = fill; v.lg = lg;
      return v;
   endfunction

   vec_t tbl [26];

   // reference model state
   logic [7:0] mq [$];
   int         m_wp, m_rp, win;
   logic       m_lg, m_pop;

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      //          rst fl v0 d0     v1 d1     rr  r0 r1 wa rv rd     fill lg
      tbl[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 0, 1);
      tbl[1]  = mk(0, 0, 1, 8'h11, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 1);
      tbl[2]  = mk(0, 0, 1, 8'h22, 0, 8'h00, 0,  1, 0, 1, 1, 8'h11, 1, 0);
      tbl[3]  = mk(0, 0, 1, 8'h33, 0, 8'h00, 0,  1, 0, 2, 1, 8'h11, 2, 0);
      tbl[4]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 3, 1, 8'h11, 3, 0);
      tbl[5]  = mk(1, 0, 1, 8'h44, 0, 8'h00, 0,  0, 0, 3, 1, 8'h11, 3, 0);
      tbl[6]  = mk(0, 0, 1, 8'hA0, 1, 8'hB0, 0,  1, 0, 0, 0, 8'h00, 0, 1);
      tbl[7]  = mk(0, 0, 1, 8'hA1, 1, 8'hB0, 0,  0, 1, 1, 1, 8'hA0, 1, 0);
      tbl[8]  = mk(0, 0, 1, 8'hA1, 1, 8'hB1, 0,  1, 0, 2, 1, 8'hA0, 2, 1);
      tbl[9]  = mk(0, 0, 1, 8'hA2, 1, 8'hB1, 0,  0, 1, 3, 1, 8'hA0, 3, 0);
      tbl[10] = mk(0, 0, 1, 8'hA2, 1, 8'hB2, 0,  1, 0, 4, 1, 8'hA0, 4, 1);
      tbl[11] = mk(0, 0, 1, 8'hA3, 1, 8'hB2, 0,  0, 1, 5, 1, 8'hA0, 5, 0);
      tbl[12] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hA0, 6, 1);
      tbl[13] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hB0, 5, 1);
      tbl[14] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hA1, 4, 1);
      tbl[15] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hB1, 3, 1);
      tbl[16] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hA2, 2, 1);
      tbl[17] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 6, 1, 8'hB2, 1, 1);
      tbl[18] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 6, 0, 8'h00, 0, 1);
      tbl[19] = mk(0, 0, 1, 8'h5C, 0, 8'h00, 1,  1, 0, 6, 0, 8'h00, 0, 1);
      tbl[20] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 7, 1, 8'h5C, 1, 0);
      tbl[21] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 7, 1, 8'h5C, 1, 0);
      tbl[22] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 7, 0, 8'h00, 0, 0);
      tbl[23] = mk(0, 0, 0, 8'h00, 1, 8'h77, 0,  0, 1, 7, 0, 8'h00, 0, 0);
      tbl[24] = mk(0, 1, 0, 8'h00, 1, 8'h78, 0,  0, 0, 0, 1, 8'h77, 1, 1);
      tbl[25] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, 0, 1);

      drive(1, 0, 0, 0, 0, 0, 0);
      tick(); tick();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].fl, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rr);
         #2;
         chk($sformatf("tbl%0d req0_ready", i), req0_ready, tbl[i].r0);
         chk($sformatf("tbl%0d req1_ready", i), req1_ready, tbl[i].r1);
         chk($sformatf("tbl%0d mem_wr_en", i), mem_wr_en, tbl[i].r0 | tbl[i].r1);
         chk($sformatf("tbl%0d mem_wr_addr", i), mem_wr_addr, tbl[i].wa);
         if (tbl[i].r0 | tbl[i].r1)
            chk($sformatf("tbl%0d mem_wr_data", i), mem_wr_data, tbl[i].r1 ? tbl[i].d1 : tbl[i].d0);
         chk($sformatf("tbl%0d rd_valid", i), rd_valid, tbl[i].rv);
         chk($sformatf("tbl%0d empty", i), empty, !tbl[i].rv);
         if (tbl[i].rv) chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].rd);
         chk($sformatf("tbl%0d fill_level", i), fill_level, tbl[i].fill);
         chk($sformatf("tbl%0d last_grant", i), last_grant, tbl[i].lg);
         tick();
      end

      // fill to full, then a pop alongside a refused push
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, 8'h40 + 8'(k), 0, 0, 0);
         #2;
         chk("fill fill_level", fill_level, k);
         chk("fill req0_ready", req0_ready, 1);
         chk("fill mem_wr_addr", mem_wr_addr, k);
         tick();
      end
      drive(0, 0, 1, 8'h48, 1, 8'h99, 0);
      #2;
      chk("full flag", full, 1);
      chk("full fill_level", fill_level, 8);
      chk("full req0_ready", req0_ready, 0);
      chk("full req1_ready", req1_ready, 0);
      chk("full mem_wr_en", mem_wr_en, 0);
      tick();
      drive(0, 0, 1, 8'h48, 0, 0, 1);
      #2;
      chk("fullpop req0_ready", req0_ready, 0);
      chk("fullpop rd_data", rd_data, 8'h40);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("fullpop fill_level", fill_level, 7);
      chk("fullpop full", full, 0);
      chk("fullpop next rd_data", rd_data, 8'h41);
      drive(0, 1, 0, 0, 0, 0, 0);
      tick();

      // pointer wrap with four entries in flight
      for (int k = 0; k < 16; k++) begin
         drive(0, 0, k < 12, 8'hC0 + 8'(k), 0, 0, k >= 4);
         #2;
         chk("wrap fill_level", fill_level, (k < 4) ? k : (k < 12) ? 4 : 16 - k);
         if (k < 12) chk("wrap mem_wr_addr", mem_wr_addr, k % 8);
         if (k >= 4) begin
            chk("wrap rd_data", rd_data, 8'hC0 + 8'(k - 4));
            chk("wrap mem_rd_addr", mem_rd_addr, (k - 4) % 8);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("wrap drained empty", empty, 1);

      // flush then reset at fill level 5 while req1 is waiting
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 8'h60 + 8'(k), 0, 0, 0);
            tick();
         end
         drive(pass == 1, pass == 0, 0, 0, 1, 8'h5A, 0);
         #2;
         chk("clr fill_level before", fill_level, 5);
         chk("clr req1_ready", req1_ready, 0);
         chk("clr mem_wr_en", mem_wr_en, 0);
         tick();
         drive(0, 0, 0, 0, 0, 0, 0);
         #2;
         chk("clr empty", empty, 1);
         chk("clr fill_level", fill_level, 0);
         chk("clr rd_valid", rd_valid, 0);
         chk("clr last_grant", last_grant, pass == 1 ? 1'b1 : 1'b0);
      end

      // random traffic against the queue model
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      mq.delete(); m_wp = 0; m_rp = 0; m_lg = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0,
               $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom),
               $urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 35 : 75));
         #2;
         win = -1;
         if (!(W_RST || flush || mq.size() == 8)) begin
            if (req0_valid && req1_valid) win = m_lg ? 0 : 1;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
         end
         m_pop = !W_RST && !flush && mq.size() > 0 && rd_ready;
         chk("rnd req0_ready", req0_ready, win == 0);
         chk("rnd req1_ready", req1_ready, win == 1);
         chk("rnd mem_wr_en", mem_wr_en, win >= 0);
         chk("rnd mem_wr_addr", mem_wr_addr, m_wp);
         if (win >= 0) chk("rnd mem_wr_data", mem_wr_data, win == 1 ? req1_data : req0_data);
         chk("rnd mem_rd_addr", mem_rd_addr, m_rp);
         chk("rnd fill_level", fill_level, mq.size());
         chk("rnd full", full, mq.size() == 8);
         chk("rnd empty", empty, mq.size() == 0);
         chk("rnd rd_valid", rd_valid, mq.size() != 0);
         if (mq.size() != 0) chk("rnd rd_data", rd_data, mq[0]);
         chk("rnd last_grant", last_grant, m_lg);
         tick();
         if (W_RST) begin
            mq.delete(); m_wp = 0; m_rp = 0; m_lg = 1'b1;
         end else if (flush) begin
            mq.delete(); m_wp = 0; m_rp = 0;
         end else begin
            if (m_pop) begin
               void'(mq.pop_front());
               m_rp = (m_rp + 1) % 8;
            end
            if (win >= 0) begin
               mq.push_back(win == 1 ? req1_data : req0_data);
               m_wp = (m_wp + 1) % 8;
               m_lg = (win == 1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
